store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Sits directly downstream of the Datapath store port (memwrite, dataadr, writedata) and upstream of data memory.
- Captures each store into a circular FIFO and drains entries to memory over a valid/ready request channel, so memory wait cycles do not stall the core unless the buffer is full.
- Provides word-granular store-to-load forwarding so that a load issued while a matching store is still pending returns the newest buffered data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous, active-low reset.
- memwrite  in  1  store request from Datapath.
- dataadr  in  AW  store byte address.
- writedata  in  DW  store data.
- stall  out  1  combinational, equals memwrite & full; the store is not accepted this cycle.
- load_en  in  1  load lookup enable.
- load_addr  in  AW  load byte address.
- fwd_hit  out  1  combinational forwarding hit.
- fwd_data  out  DW  combinational forwarded data; 0 when there is no hit.
- mem_req_valid  out  1  head entry is valid.
- mem_req_ready  in  1  memory accepts the head entry.
- mem_req_addr  out  AW  head entry address, unchanged from capture.
- mem_req_data  out  DW  head entry data.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Storage:
  - DEPTH entries of {addr, data}.
  - Registers wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Registered count.
- Reset (clear_n low, asynchronous):
  - wr_ptr=rd_ptr=0, count=0, all entries cleared to 0.
  - Outputs: empty=1, full=0, mem_req_valid=0, mem_req_addr=0, mem_req_data=0, fwd_hit=0, fwd_data=0, stall=0 while memwrite=0.
  - Reset mid-operation discards all pending stores; no memory request is issued for them.
- Enqueue:
  - Condition: memwrite & !full at a rising edge.
  - Writes entry[wr_ptr] and increments wr_ptr.
  - Latency: the entry is visible on mem_req_* and to forwarding from the next cycle.
  - No same-cycle bypass to memory or to forwarding.
- Dequeue:
  - Condition: mem_req_valid & mem_req_ready at a rising edge.
  - Increments rd_ptr.
- Request channel:
  - mem_req_valid = !empty.
  - mem_req_addr and mem_req_data come from entry[rd_ptr].
  - While valid is high and ready is low, addr and data hold stable.
  - Valid never drops without a handshake, except on reset.
- Count update, per cycle: count += enq - deq.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Both pointers advance.
- Full:
  - Enqueue is blocked even when a dequeue happens in the same cycle.
  - stall stays high for that cycle; the store is accepted the following cycle if it is still presented.
- Empty: a dequeue cannot occur because valid=0; ready is ignored.
- Ordering:
  - Strict FIFO; memory sees stores in program order.
  - Duplicate addresses are kept as separate entries with no merging.
- Forwarding:
  - With load_en=1, compare load_addr[AW-1:2] against addr[AW-1:2] of every occupied entry.
  - On multiple matches, the youngest entry (closest to wr_ptr-1) wins.
  - fwd_hit=1 and fwd_data = that entry's data.
  - With load_en=0 or no match: fwd_hit=0 and fwd_data=0.
  - An entry dequeued on the current edge is no longer considered from the next cycle.
  - The same-cycle incoming store is not considered.
- Address bits [1:0] are stored and forwarded unchanged and play no part in matching.

Test Plan:
1. Reset, then a store of dataadr=0x10000054, writedata=64 with mem_req_ready=1 -> next cycle mem_req_valid=1, addr 0x10000054, data 64, count=1; the cycle after that: empty=1, count=0.
2. mem_req_ready=0, stores to 0x10000000, 0x10000004, 0x10000008, 0x1000000C with data 1..4, then a fifth store -> full=1, count=4, stall=1 on the fifth store; raise ready -> drains 1,2,3,4 in order and the fifth store is accepted once full drops.
3. Full buffer, memwrite and ready both high in the same cycle -> one dequeue, no enqueue, count goes to 3, stall=1; the store enters the next cycle and count returns to 4.
4. ready=0, stores 0x10000054=7, 0x10000058=9, 0x10000056=11; load_addr=0x10000054 -> fwd_hit=1, fwd_data=11; load_addr=0x10000060 -> fwd_hit=0, fwd_data=0; load_en=0 -> fwd_hit=0.
5. Pointer wrap: with ready toggled, push and drain 10 stores (data 0x10..0x19) -> memory receives all 10 in order, none lost or duplicated, empty=1 at the end.
6. Three entries pending with ready=0, clear_n pulsed low between clock edges -> immediately count=0, empty=1, mem_req_valid=0, fwd_hit=0; after release, no stale request appears.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// Store-port and memory-request bundle for store_write_buffer.
// The master side is the core/memory environment; the slave side is the buffer.
interface store_write_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output memwrite, dataadr, writedata, load_en, load_addr, mem_req_ready,
        input  stall, fwd_hit, fwd_data, mem_req_valid, mem_req_addr, mem_req_data,
        input  count, empty, full
    );

    modport slave (
        input  memwrite, dataadr, writedata, load_en, load_addr, mem_req_ready,
        output stall, fwd_hit, fwd_data, mem_req_valid, mem_req_addr, mem_req_data,
        output count, empty, full
    );
endinterface

// File: rtl/store_write_buffer.sv
// Circular store buffer between the Datapath store port and data memory,
// draining over valid/ready with word-granular store-to-load forwarding.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                clock,
    input  logic                clear_n,
    store_write_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic full_w;
    logic empty_w;
    logic enq;
    logic deq;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    // Full blocks the store even if the head drains on the same edge.
    assign enq     = bus.memwrite & ~full_w;
    assign deq     = ~empty_w & bus.mem_req_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                addr_q[wr_ptr] <= bus.dataadr;
                data_q[wr_ptr] <= bus.writedata;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(deq);
        end
    end

    assign bus.stall         = bus.memwrite & full_w;
    assign bus.mem_req_valid = ~empty_w;
    assign bus.mem_req_addr  = addr_q[rd_ptr];
    assign bus.mem_req_data  = data_q[rd_ptr];
    assign bus.count         = count_q;
    assign bus.empty         = empty_w;
    assign bus.full          = full_w;

    // Walk occupied entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        idx          = '0;
        if (bus.load_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count_q) &&
                    (((bus.load_addr ^ addr_q[idx]) & WORD_MASK) == '0)) begin
                    bus.fwd_hit  = 1'b1;
                    bus.fwd_data = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: accepted stores are queued by a
// negedge monitor and compared against each memory handshake in order.
module tb_store_write_buffer;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   model_count = 0;
    int   n_popped = 0;
    bit   mon_en = 1'b0;
    ent_t sb[$];

    store_write_buffer_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) bus ();

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Negedge monitor: checks status against the reference occupancy model,
    // pops the scoreboard on every handshake, pushes every accepted store.
    always @(negedge clock) begin
        if (mon_en) begin
            bit m_enq, m_deq;
            ent_t e;
            checks++;
            if (bus.count !== model_count[3:0]) begin
                errors++;
                $display("FAIL mon_count: got %0d expected %0d", bus.count, model_count);
            end
            checks++;
            if (bus.stall !== (bus.memwrite && model_count == DEPTH)) begin
                errors++;
                $display("FAIL mon_stall: got %b expected %b", bus.stall,
                         (bus.memwrite && model_count == DEPTH));
            end
            checks++;
            if (bus.mem_req_valid !== (model_count != 0)) begin
                errors++;
                $display("FAIL mon_valid: got %b expected %b", bus.mem_req_valid, model_count != 0);
            end
            m_deq = (model_count != 0) && bus.mem_req_ready;
            m_enq = bus.memwrite && (model_count != DEPTH);
            if (m_deq) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_pop: handshake with empty scoreboard addr %h", bus.mem_req_addr);
                end else begin
                    e = sb.pop_front();
                    n_popped++;
                    if (bus.mem_req_addr !== e.a || bus.mem_req_data !== e.d) begin
                        errors++;
                        $display("FAIL mon_req: got %h/%h expected %h/%h",
                                 bus.mem_req_addr, bus.mem_req_data, e.a, e.d);
                    end
                end
            end
            if (m_enq) sb.push_back('{a: bus.dataadr, d: bus.writedata});
            model_count = model_count + int'(m_enq) - int'(m_deq);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        bus.memwrite = 1'b0;
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 30 && !bus.empty; k++) step();
        checks++;
        if (bus.empty !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: empty %b sb %0d expected empty 1 sb 0", name, bus.empty, sb.size());
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        bus.memwrite = 1'b0;
        bus.dataadr = '0;
        bus.writedata = '0;
        bus.load_en = 1'b1;
        bus.load_addr = '0;
        bus.mem_req_ready = 1'b0;
        #12;
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.mem_req_valid !== 1'b0 ||
            bus.count !== 3'd0 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: empty %b full %b valid %b count %0d stall %b expected 1 0 0 0 0",
                     bus.empty, bus.full, bus.mem_req_valid, bus.count, bus.stall);
        end
        checks++;
        if (bus.mem_req_addr !== 32'h0 || bus.mem_req_data !== 32'h0 ||
            bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h data %h hit %b fwd %h expected zeros",
                     bus.mem_req_addr, bus.mem_req_data, bus.fwd_hit, bus.fwd_data);
        end
        bus.load_en = 1'b0;
        clear_n = 1'b1;
        step();
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        bus.mem_req_ready = 1'b1;
        bus.memwrite = 1'b1;
        bus.dataadr = 32'h1000_0054;
        bus.writedata = 32'd64;
        step();
        bus.memwrite = 1'b0;
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h1000_0054 ||
            bus.mem_req_data !== 32'd64 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL single_req: valid %b addr %h data %0d count %0d expected 1 10000054 64 1",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_data, bus.count);
        end
        step();
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL single_drain: empty %b count %0d expected 1 0", bus.empty, bus.count);
        end
    endtask

    task automatic test_fill();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.memwrite = 1'b1;
            bus.dataadr = 32'h1000_0000 + 32'(4 * i);
            bus.writedata = 32'(i + 1);
            step();
        end
        bus.dataadr = 32'h1000_0010;
        bus.writedata = 32'd5;
        #1;
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: full %b count %0d stall %b expected 1 4 1",
                     bus.full, bus.count, bus.stall);
        end
        bus.mem_req_ready = 1'b1;
        step();
        checks++;
        if (bus.count !== 3'd3 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL fill_unblock: count %0d stall %b expected 3 0", bus.count, bus.stall);
        end
        step();
        drain("fill");
        checks++;
        if (n_popped != 6) begin
            errors++;
            $display("FAIL fill_popped: got %0d expected 6", n_popped);
        end
    endtask

    task automatic test_full_simul();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.memwrite = 1'b1;
            bus.dataadr = 32'h1000_0200 + 32'(4 * i);
            bus.writedata = 32'h21 + 32'(i);
            step();
        end
        bus.dataadr = 32'h1000_0210;
        bus.writedata = 32'h25;
        bus.mem_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL simul_stall: got %b expected 1", bus.stall);
        end
        step();
        bus.mem_req_ready = 1'b0;
        checks++;
        if (bus.count !== 3'd3 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL simul_deq_only: count %0d stall %b expected 3 0", bus.count, bus.stall);
        end
        step();
        bus.memwrite = 1'b0;
        checks++;
        if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL simul_refill: count %0d full %b expected 4 1", bus.count, bus.full);
        end
        drain("simul");
    endtask

    task automatic test_forward();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h1000_0054, 32'h1000_0058, 32'h1000_0056};
        datas = '{32'd7, 32'd9, 32'd11};
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.memwrite = 1'b1;
            bus.dataadr = addrs[i];
            bus.writedata = datas[i];
            step();
        end
        bus.memwrite = 1'b0;
        bus.load_en = 1'b1;
        bus.load_addr = 32'h1000_0054;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd11) begin
            errors++;
            $display("FAIL fwd_youngest: hit %b data %0d expected 1 11", bus.fwd_hit, bus.fwd_data);
        end
        bus.load_addr = 32'h1000_0058;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd9) begin
            errors++;
            $display("FAIL fwd_single: hit %b data %0d expected 1 9", bus.fwd_hit, bus.fwd_data);
        end
        bus.load_addr = 32'h1000_0060;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin
            errors++;
            $display("FAIL fwd_miss: hit %b data %0d expected 0 0", bus.fwd_hit, bus.fwd_data);
        end
        bus.load_addr = 32'h1000_0054;
        bus.load_en = 1'b0;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin
            errors++;
            $display("FAIL fwd_disabled: hit %b data %0d expected 0 0", bus.fwd_hit, bus.fwd_data);
        end
        bus.load_en = 1'b1;
        bus.load_addr = 32'h1000_0070;
        bus.memwrite = 1'b1;
        bus.dataadr = 32'h1000_0070;
        bus.writedata = 32'd99;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_no_bypass: hit %b expected 0", bus.fwd_hit);
        end
        step();
        bus.memwrite = 1'b0;
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd99) begin
            errors++;
            $display("FAIL fwd_next_cycle: hit %b data %0d expected 1 99", bus.fwd_hit, bus.fwd_data);
        end
        drain("fwd");
        bus.load_addr = 32'h1000_0054;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_after_drain: hit %b expected 0", bus.fwd_hit);
        end
        bus.load_en = 1'b0;
    endtask

    task automatic test_wrap();
        int base;
        int budget;
        base = n_popped;
        for (int i = 0; i < 10; i++) begin
            bus.memwrite = 1'b1;
            bus.dataadr = 32'h1000_0100 + 32'(4 * i);
            bus.writedata = 32'h10 + 32'(i);
            budget = 0;
            do begin
                bus.mem_req_ready = ~bus.mem_req_ready;
                #1;
                if (!bus.stall) break;
                step();
                budget++;
            end while (budget < 20);
            step();
        end
        drain("wrap");
        checks++;
        if (n_popped - base != 10) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 10", n_popped - base);
        end
    endtask

    task automatic test_reset_mid();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.memwrite = 1'b1;
            bus.dataadr = 32'h1000_0300 + 32'(4 * i);
            bus.writedata = 32'h40 + 32'(i);
            step();
        end
        bus.memwrite = 1'b0;
        bus.load_en = 1'b1;
        bus.load_addr = 32'h1000_0300;
        mon_en = 1'b0;
        sb.delete();
        model_count = 0;
        #1;
        clear_n = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.mem_req_valid !== 1'b0 ||
            bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL midreset: count %0d empty %b valid %b hit %b expected 0 1 0 0",
                     bus.count, bus.empty, bus.mem_req_valid, bus.fwd_hit);
        end
        clear_n = 1'b1;
        bus.load_en = 1'b0;
        bus.mem_req_ready = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale: valid %b expected 0 at cycle %0d", bus.mem_req_valid, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_simul();
        test_forward();
        test_wrap();
        test_reset_mid();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
